// File: rtl/cdc_sync_multi_edge.sv
// Multi-channel level synchroniser: sync chain, stability filter, mode-qualified
// edge pulses and saturating per-channel event counters.
module cdc_sync_multi_edge #(
  parameter int unsigned   CH          = 8,
  parameter int unsigned   SYNC_STAGES = 2,
  parameter int unsigned   FILT_CYCLES = 4,
  parameter int unsigned   EVT_W       = 8,
  parameter logic [CH-1:0] RESET_VAL   = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CH-1:0]       async_in,
  input  logic [1:0]          mode,
  input  logic                evt_clr,
  output logic [CH-1:0]       sync_out,
  output logic [CH-1:0]       pulse_out,
  output logic [CH*EVT_W-1:0] evt_cnt
);

  localparam int unsigned FW   = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam int unsigned FMAX = FILT_CYCLES - 1;

  logic [SYNC_STAGES-1:0][CH-1:0] chain;
  logic [CH-1:0][FW-1:0]          fcnt;
  logic [CH-1:0][EVT_W-1:0]       cnt;
  logic [CH-1:0]                  s;
  logic [CH-1:0]                  lvl_d;
  logic [1:0]                     mode_q;
  logic [CH-1:0]                  rise_c;
  logic [CH-1:0]                  fall_c;
  logic [CH-1:0]                  qual_c;

  assign s       = chain[SYNC_STAGES-1];
  assign evt_cnt = cnt;

  // Plain flop chain, nothing between stages
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) chain[k] <= RESET_VAL;
    end else begin
      chain[0] <= async_in;
      for (int k = 1; k < SYNC_STAGES; k++) chain[k] <= chain[k-1];
    end
  end

  // Stability filter: sync_out follows s only after FILT_CYCLES consecutive differing cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fcnt     <= '0;
      sync_out <= RESET_VAL;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (s[i] == sync_out[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FMAX)) begin
          sync_out[i] <= s[i];
          fcnt[i]     <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FW'(1);
        end
      end
    end
  end

  // Edge qualification uses the registered mode so a mode change never makes a pulse itself
  always_comb begin
    rise_c = sync_out & ~lvl_d;
    fall_c = ~sync_out & lvl_d;
    qual_c = '0;
    case (mode_q)
      2'b01:   qual_c = rise_c;
      2'b10:   qual_c = fall_c;
      2'b11:   qual_c = rise_c | fall_c;
      default: qual_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lvl_d     <= RESET_VAL;
      mode_q    <= '0;
      pulse_out <= '0;
    end else begin
      lvl_d     <= sync_out;
      mode_q    <= mode;
      pulse_out <= qual_c;
    end
  end

  // Saturating event counters; clear wins over a coincident event
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (evt_clr) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (qual_c[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + EVT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cdc_sync_multi_edge.sv
// Directed bench for cdc_sync_multi_edge with CH=8, SYNC_STAGES=2, FILT_CYCLES=4, EVT_W=8.
module tb_cdc_sync_multi_edge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  async_in;
  logic [1:0]  mode;
  logic        evt_clr;
  logic [7:0]  sync_out;
  logic [7:0]  pulse_out;
  logic [63:0] evt_cnt;

  int checks = 0;
  int errors = 0;
  logic [7:0] pseen;
  int         pcount;

  cdc_sync_multi_edge #(
    .CH(8), .SYNC_STAGES(2), .FILT_CYCLES(4), .EVT_W(8), .RESET_VAL(8'h00)
  ) dut (
    .clk(clk), .reset_n(reset_n), .async_in(async_in), .mode(mode),
    .evt_clr(evt_clr), .sync_out(sync_out), .pulse_out(pulse_out), .evt_cnt(evt_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance n cycles while recording every pulse seen
  task automatic run(input int n);
    for (int j = 0; j < n; j++) begin
      tick();
      pseen  |= pulse_out;
      pcount += $countones(pulse_out);
    end
  endtask

  task automatic clear_pulses();
    pseen  = '0;
    pcount = 0;
  endtask

  initial begin
    reset_n  = 1'b0;
    async_in = 8'h00;
    mode     = 2'b11;
    evt_clr  = 1'b0;
    clear_pulses();
    run(3);
    check("rst_sync", 64'(sync_out), 64'h0);
    check("rst_pulse", 64'(pulse_out), 64'h0);
    check("rst_cnt", evt_cnt, 64'h0);
    reset_n = 1'b1;
    run(2);

    // 1: single rise through full latency
    async_in = 8'h02;
    run(5);
    check("t1_sync_e5", 64'(sync_out), 64'h00);
    tick();
    check("t1_sync_e6", 64'(sync_out), 64'h02);
    check("t1_pulse_e6", 64'(pulse_out), 64'h00);
    tick();
    check("t1_pulse_e7", 64'(pulse_out), 64'h02);
    check("t1_cnt", evt_cnt, 64'h0000_0000_0000_0100);
    tick();
    check("t1_pulse_e8", 64'(pulse_out), 64'h00);

    // 2: three-cycle glitch on bit3 rejected
    clear_pulses();
    async_in = 8'h0A;
    run(3);
    async_in = 8'h02;
    run(12);
    check("t2_sync", 64'(sync_out), 64'h02);
    check("t2_pulses", 64'(pseen), 64'h00);
    check("t2_cnt", evt_cnt, 64'h0000_0000_0000_0100);

    // 3: rise-only mode
    mode = 2'b01;
    clear_pulses();
    async_in = 8'h00;
    run(12);
    check("t3_fall_ignored", 64'(pseen), 64'h00);
    check("t3_sync_low", 64'(sync_out), 64'h00);
    evt_clr = 1'b1;
    tick();
    evt_clr = 1'b0;
    check("t3_clr", evt_cnt, 64'h0);
    async_in = 8'h0E;
    run(6);
    check("t3_sync_hi", 64'(sync_out), 64'h0E);
    check("t3_pulse_e6", 64'(pulse_out), 64'h00);
    tick();
    check("t3_pulse_e7", 64'(pulse_out), 64'h0E);
    clear_pulses();
    run(4);
    async_in = 8'h00;
    run(12);
    check("t3_no_fall_pulse", 64'(pseen), 64'h00);
    check("t3_cnt", evt_cnt, 64'h0000_0000_0101_0100);

    // 4: saturation on bit0
    mode = 2'b11;
    evt_clr = 1'b1;
    tick();
    evt_clr = 1'b0;
    for (int k = 0; k < 300; k++) begin
      async_in[0] = ~async_in[0];
      run(12);
      if (k == 9) check("t4_cnt10", evt_cnt, 64'h0A);
    end
    check("t4_sat", evt_cnt, 64'hFF);
    run(12);
    check("t4_sat_hold", evt_cnt, 64'hFF);
    evt_clr = 1'b1;
    tick();
    evt_clr = 1'b0;
    check("t4_clr", evt_cnt, 64'h0);

    // 5: clear coincident with the pulse cycle wins
    async_in = 8'h01;
    run(6);
    check("t5_sync", 64'(sync_out), 64'h01);
    evt_clr = 1'b1;
    tick();
    evt_clr = 1'b0;
    check("t5_pulse", 64'(pulse_out), 64'h01);
    check("t5_cnt_clr", evt_cnt, 64'h0);
    tick();
    check("t5_cnt_after", evt_cnt, 64'h0);
    async_in = 8'h00;
    run(12);
    check("t5_cnt_fall", evt_cnt, 64'h01);

    // 6: reset mid-filter, input held across reset
    async_in = 8'h02;
    run(4);
    reset_n = 1'b0;
    #1;
    check("t6_rst_sync", 64'(sync_out), 64'h00);
    check("t6_rst_pulse", 64'(pulse_out), 64'h00);
    check("t6_rst_cnt", evt_cnt, 64'h0);
    clear_pulses();
    run(3);
    check("t6_no_pulse_rst", 64'(pseen), 64'h00);
    check("t6_sync_in_rst", 64'(sync_out), 64'h00);
    reset_n = 1'b1;
    clear_pulses();
    run(5);
    check("t6_sync_e5", 64'(sync_out), 64'h00);
    run(1);
    check("t6_sync_e6", 64'(sync_out), 64'h02);
    run(1);
    check("t6_pulse_e7", 64'(pulse_out), 64'h02);
    check("t6_cnt", evt_cnt, 64'h0000_0000_0000_0100);
    run(5);
    check("t6_one_pulse", 64'(pcount), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
